elm_output_layer: RTL and testbench

- Output stage of the ELM inference engine. Sits directly downstream of the hidden-layer stage.
- After that stage signals completion on update, this block multiplies the ReLU'd hidden vector H (300 x 21-bit) by the trained output-weight matrix beta (300 x 10, signed 16-bit).
- One MAC per clock. Weights are read from an external synchronous ROM.
- Performs argmax over the 10 class scores and presents the predicted class with a single-cycle valid pulse.

---
 rtl/elm_pkg.sv | 34 +++
 rtl/elm_output_layer_mac.sv | 42 ++++
 rtl/elm_output_layer.sv | 186 ++++++++++++++++++
 tb/tb_elm_output_layer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared definitions for the ELM output layer.
// Contents: layer dimensions and datapath widths, the FSM state encoding,
// and hidden_lsb(), which maps a 1-based hidden node index to the LSB
// position of that node inside the packed Hidden vector.
package elm_pkg;

  localparam int BIT_LENGTH   = 21;
  localparam int LAYER_1_SIZE = 300;
  localparam int NUM_CLASSES  = 10;
  localparam int W_WIDTH      = 16;
  localparam int ACC_WIDTH    = 46;
  localparam int ADDR_WIDTH   = 12;
  localparam int PROD_WIDTH   = BIT_LENGTH + W_WIDTH;
  localparam int HID_WIDTH    = BIT_LENGTH * LAYER_1_SIZE;
  localparam int HID_IDX_W    = 13;
  localparam int CNT_WIDTH    = 9;
  localparam int CLS_WIDTH    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } elm_state_e;

  // Node 1 is the leftmost (most significant) slice, so node k starts
  // BIT_LENGTH*(LAYER_1_SIZE-k) bits above bit 0. Valid for k in 1..300.
  function automatic logic [HID_IDX_W-1:0] hidden_lsb(input logic [CNT_WIDTH-1:0] k);
    int tmp;
    tmp = BIT_LENGTH * (LAYER_1_SIZE - int'(k));
    return HID_IDX_W'(tmp);
  endfunction

endpackage

// File: rtl/elm_output_layer_mac.sv
// Registered signed multiply-accumulate for the ELM output layer.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr          : clear accumulator (priority over en)
//   en           : accumulate h * w this cycle
//   h            : unsigned hidden value (zero-extended before multiply)
//   w            : signed weight
//   acc          : signed accumulator
module elm_mac
  import elm_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic [BIT_LENGTH-1:0]       h,
  input  logic [W_WIDTH-1:0]          w,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;

  // The product of a 21-bit unsigned and a 16-bit signed value always fits
  // in 37 signed bits, so the truncated multiply is exact.
  always_comb begin
    prod  = $signed({1'b0, h}) * $signed(w);
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  end

  always_ff @(posedge clock) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/elm_output_layer.sv
// ELM output layer: scores = H * beta over 300 hidden nodes and 10 classes,
// one MAC per clock from an external synchronous weight ROM, followed by a
// running argmax. The predicted class is presented with a one-cycle valid.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   Hidden       : packed hidden vector, node 1 leftmost, held stable by
//                  upstream from the update edge until valid_out
//   update       : completion strobe from hidden stage (rising edge starts)
//   weight_addr  : ROM address c*300 + (k-1)
//   weight_data  : signed beta[k][c], one cycle after weight_addr
//   busy         : inference in progress
//   class_out    : predicted class, held until next valid_out or reset
//   valid_out    : one-cycle pulse when class_out updates
//   scores       : per-class final accumulators (only with ELM_SCORES_OUT_EN)
// Optional build macro: ELM_SCORES_OUT_EN.
module elm_output_layer
  import elm_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [HID_WIDTH-1:0]                 Hidden,
  input  logic                                 update,
  output logic [ADDR_WIDTH-1:0]                weight_addr,
  input  logic [W_WIDTH-1:0]                   weight_data,
  output logic                                 busy,
  output logic [CLS_WIDTH-1:0]                 class_out,
  output logic                                 valid_out
`ifdef ELM_SCORES_OUT_EN
  ,
  output logic [NUM_CLASSES*ACC_WIDTH-1:0]     scores
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_NODE = CNT_WIDTH'(LAYER_1_SIZE);
  localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(LAYER_1_SIZE - 1);
  localparam logic [CLS_WIDTH-1:0] LAST_CLS  = CLS_WIDTH'(NUM_CLASSES - 1);
  localparam logic [ACC_WIDTH-1:0] MOST_NEG  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  elm_state_e                  state_q, state_d;
  logic [CLS_WIDTH-1:0]        c_q, c_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic signed [ACC_WIDTH-1:0] best_score_q, best_score_d;
  logic [CLS_WIDTH-1:0]        best_idx_q, best_idx_d;
  logic                        busy_q, busy_d;
  logic                        valid_q, valid_d;
  logic [CLS_WIDTH-1:0]        class_q, class_d;
  logic                        update_q;
`ifdef ELM_SCORES_OUT_EN
  logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0] scores_q, scores_d;
`endif

  logic                        start;
  logic                        mac_clr, mac_en, gt;
  logic [CNT_WIDTH-1:0]        node;
  logic [BIT_LENGTH-1:0]       h_sel;
  logic signed [ACC_WIDTH-1:0] acc;

  assign start = (state_q == S_IDLE) && update && !update_q;

  // In MAC cycle cnt=j the ROM delivers the weight for node j (addressed in
  // the previous cycle), so node j is the hidden value to pair with it.
  // cnt=0 has no data yet; node 1 is selected only to keep the index legal.
  assign node  = (cnt_q == '0) ? CNT_WIDTH'(1) : cnt_q;
  assign h_sel = Hidden[hidden_lsb(node) +: BIT_LENGTH];
  assign gt    = acc > best_score_q;

  elm_mac u_mac (
    .clock (clock),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .h     (h_sel),
    .w     (weight_data),
    .acc   (acc)
  );

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    class_d      = class_q;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
`ifdef ELM_SCORES_OUT_EN
    scores_d     = scores_q;
`endif
    case (state_q)
      S_IDLE: begin
        mac_clr = 1'b1;
        if (start) begin
          c_d          = '0;
          cnt_d        = '0;
          addr_d       = '0;
          best_score_d = MOST_NEG;
          best_idx_d   = '0;
          busy_d       = 1'b1;
          state_d      = S_MAC;
`ifdef ELM_SCORES_OUT_EN
          scores_d     = '0;
`endif
        end
      end
      S_MAC: begin
        mac_en = (cnt_q != '0);
        // The node-300 address is already out when cnt reaches 299; from
        // then on the address holds while the pipeline drains.
        if (cnt_q < LAST_ADDR) addr_d = addr_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_NODE) state_d = S_CMP;
        else                    cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      S_CMP: begin
        mac_clr = 1'b1;
        if (gt) begin
          best_score_d = acc;
          best_idx_d   = c_q;
        end
`ifdef ELM_SCORES_OUT_EN
        scores_d[c_q] = acc;
`endif
        if (c_q == LAST_CLS) begin
          class_d = gt ? c_q : best_idx_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          c_d     = c_q + CLS_WIDTH'(1);
          cnt_d   = '0;
          // Last address of class c plus one is node 1 of class c+1.
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      c_q          <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      class_q      <= '0;
      update_q     <= 1'b0;
`ifdef ELM_SCORES_OUT_EN
      scores_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      class_q      <= class_d;
      update_q     <= update;
`ifdef ELM_SCORES_OUT_EN
      scores_q     <= scores_d;
`endif
    end
  end

  assign weight_addr = addr_q;
  assign busy        = busy_q;
  assign valid_out   = valid_q;
  assign class_out   = class_q;
`ifdef ELM_SCORES_OUT_EN
  assign scores      = scores_q;
`endif

endmodule

// File: tb/tb_elm_output_layer.sv
// Directed self-checking bench for elm_output_layer with a behavioural
// synchronous weight ROM. Cycle 0 is the cycle in which update is raised
// (driven at its negedge); outputs are sampled on negedges, so the negedge
// count after raising update equals the cycle number.
module tb_elm_output_layer;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          update = 1'b0;
  logic [6299:0] hidden = '0;
  logic [11:0]   weight_addr;
  logic [15:0]   weight_data = '0;
  logic          busy;
  logic [3:0]    class_out;
  logic          valid_out;
`ifdef ELM_SCORES_OUT_EN
  logic [459:0]  scores;
`endif

  logic signed [15:0] rom [0:2999];
  int n_checks = 0;
  int n_fail   = 0;

  elm_output_layer dut (
    .clock       (clock),
    .reset       (reset),
    .Hidden      (hidden),
    .update      (update),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .busy        (busy),
    .class_out   (class_out),
    .valid_out   (valid_out)
`ifdef ELM_SCORES_OUT_EN
    ,
    .scores      (scores)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    weight_data <= (weight_addr < 12'd3000) ? rom[weight_addr] : 16'h0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Node k (1-based) is the k-th 21-bit field from the left.
  task automatic set_node(input int k, input logic [20:0] v);
    hidden[6300 - 21*k +: 21] = v;
  endtask

  task automatic set_beta(input int k, input int c, input logic signed [15:0] v);
    rom[c*300 + k - 1] = v;
  endtask

  task automatic fill_rom_rand();
    for (int i = 0; i < 3000; i++) rom[i] = 16'($urandom);
  endtask

`ifdef ELM_SCORES_OUT_EN
  task automatic check_score(input string tag, input int c, input longint exp);
    logic signed [45:0] s;
    s = scores[c*46 +: 46];
    check(tag, longint'(s), exp);
  endtask
`endif

  // Raise update at the current negedge, then wait (bounded) for valid_out.
  task automatic run(input string tag, input int hold, input logic [3:0] exp_cls);
    int n;
    n = 0;
    update = 1'b1;
    while (n < 4000) begin
      @(negedge clock);
      n++;
      if (n == hold) update = 1'b0;
      if (n == 1)   begin check({tag, "_busy"}, busy, 1); check({tag, "_a0"}, weight_addr, 0); end
      if (n == 2)   check({tag, "_a1"}, weight_addr, 1);
      if (n == 303) check({tag, "_a300"}, weight_addr, 300);
      if (valid_out) break;
    end
    update = 1'b0;
    check({tag, "_lat"}, n, 3021);
    check({tag, "_cls"}, class_out, exp_cls);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic load_node5();
    fill_rom_rand();
    hidden = '0;
    set_node(5, 21'd100);
    for (int c = 0; c < 10; c++) set_beta(5, c, 16'(c - 3));
  endtask

  task automatic load_max();
    for (int k = 1; k <= 300; k++) set_node(k, 21'd1048575);
    for (int i = 0; i < 3000; i++) rom[i] = -16'sd1;
  endtask

  initial begin
    int n, cnt, first;
    fill_rom_rand();
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_valid", valid_out, 0);
    check("rst_class", class_out, 0);
    check("rst_addr", weight_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    // All-zero hidden: every score 0, tie keeps class 0.
    hidden = '0;
    run("zero", 1, 4'd0);
`ifdef ELM_SCORES_OUT_EN
    for (int c = 0; c < 10; c++) check_score("zero_score", c, 0);
`endif
    @(negedge clock);

    // Only node 5 = 100, beta[5][c] = c-3: scores 100*(c-3).
    load_node5();
    run("node5", 1, 4'd9);
`ifdef ELM_SCORES_OUT_EN
    check_score("node5_s0", 0, -300);
    check_score("node5_s4", 4, 100);
    check_score("node5_s9", 9, 600);
`endif
    @(negedge clock);

    // Max hidden, all beta -1: 300 * -1048575 = -314572500 for every class.
    load_max();
    run("max", 1, 4'd0);
`ifdef ELM_SCORES_OUT_EN
    for (int c = 0; c < 10; c++) check_score("max_score", c, -314572500);
`endif
    @(negedge clock);

    // update held 3 cycles plus a second edge at cycle 1500: one result.
    load_node5();
    update = 1'b1;
    n = 0; cnt = 0; first = -1;
    while (n < 4600) begin
      @(negedge clock);
      n++;
      if (n == 3)    update = 1'b0;
      if (n == 1500) update = 1'b1;
      if (n == 1502) update = 1'b0;
      if (n == 1501) check("held_busy", busy, 1);
      if (valid_out) begin
        cnt++;
        if (first < 0) first = n;
        check("held_cls", class_out, 9);
      end
    end
    check("held_lat", first, 3021);
    check("held_count", cnt, 1);
    @(negedge clock);

    // Reset at cycle 1000 aborts with no valid_out; class_out was 9.
    update = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(negedge clock);
      n++;
      if (n == 1)   update = 1'b0;
      if (n == 999) check("abort_busy_pre", busy, 1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_class", class_out, 0);
    check("abort_addr", weight_addr, 0);
    reset = 1'b0;
    cnt = 0;
    repeat (3100) begin
      @(negedge clock);
      if (valid_out) cnt++;
    end
    check("abort_novalid", cnt, 0);
    run("after_rst", 1, 4'd9);
    @(negedge clock);

    // Back-to-back: second edge one cycle after valid_out.
    load_max();
    run("b2b_a", 1, 4'd0);
    @(negedge clock);
    fill_rom_rand();
    hidden = '0;
    set_node(1, 21'd7);
    for (int c = 0; c < 10; c++) set_beta(1, c, (c == 4) ? 16'sd50 : -16'sd2);
    run("b2b_b", 1, 4'd4);
`ifdef ELM_SCORES_OUT_EN
    check_score("b2b_s4", 4, 350);
    check_score("b2b_s0", 0, -14);
`endif

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
